// File: rtl/gate_check_pkg.sv
// gate_check_pkg
//   Shared definitions for the gate block self-test.
//   - state_t         : sweep sequencer states
//   - GATE_* indices  : bit position of each gate output on the gate bus
//   - expected_gates  : golden truth-table value of the 7-bit gate bus for (a, b)
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned NUM_GATES = 7;

    localparam int unsigned GATE_AND  = 0;
    localparam int unsigned GATE_OR   = 1;
    localparam int unsigned GATE_NOT  = 2;  // NOT of A only
    localparam int unsigned GATE_NAND = 3;
    localparam int unsigned GATE_NOR  = 4;
    localparam int unsigned GATE_XOR  = 5;
    localparam int unsigned GATE_XNOR = 6;

    function automatic logic [NUM_GATES-1:0] expected_gates(input logic a, input logic b);
        logic [NUM_GATES-1:0] g;
        g            = '0;
        g[GATE_AND]  = a & b;
        g[GATE_OR]   = a | b;
        g[GATE_NOT]  = ~a;
        g[GATE_NAND] = ~(a & b);
        g[GATE_NOR]  = ~(a | b);
        g[GATE_XOR]  = a ^ b;
        g[GATE_XNOR] = ~(a ^ b);
        return g;
    endfunction

endpackage

// File: rtl/gate_truth_checker.sv
// gate_truth_checker
//   Built-in checker for the seven-output two-input gate block. On start it
//   walks A/B through 00, 01, 10, 11, holds each vector SETTLE_CYCLES cycles,
//   then samples the gate bus for one cycle and accumulates mismatches against
//   the golden truth table into a sticky per-gate mask.
//
// Parameters
//   SETTLE_CYCLES : cycles each vector is held before sampling (1..15)
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   sweep request, honoured only while idle
//   gate_in  in   [6:0] gate block outputs (AND,OR,NOT A,NAND,NOR,XOR,XNOR)
//   a_out    out  gate block A input (vec_idx[1])
//   b_out    out  gate block B input (vec_idx[0])
//   busy     out  sweep in progress
//   vec_idx  out  [1:0] current vector
//   done     out  one-cycle pulse at end of sweep
//   pass     out  last completed sweep had no mismatches
//   err_mask out  [6:0] sticky per-gate mismatch bits
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_GATES-1:0] gate_in,
    output logic                 a_out,
    output logic                 b_out,
    output logic                 busy,
    output logic [1:0]           vec_idx,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_GATES-1:0] err_mask
);

    // Count value on the last DRIVE cycle of a vector. The counter is 4 bits
    // and only climbs to SETTLE_CYCLES-1, so it cannot wrap for legal values.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t               state;
    logic [3:0]           settle_cnt;
    logic [NUM_GATES-1:0] sample_err;
    logic [NUM_GATES-1:0] mask_next;

    // A/B come straight from the vector register, so the gate block sees a
    // glitch-free, registered stimulus.
    assign a_out = vec_idx[1];
    assign b_out = vec_idx[0];

    assign sample_err = gate_in ^ expected_gates(vec_idx[1], vec_idx[0]);
    assign mask_next  = err_mask | sample_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            vec_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_mask   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= DRIVE;
                        busy       <= 1'b1;
                        vec_idx    <= '0;
                        err_mask   <= '0;
                        pass       <= 1'b0;
                        settle_cnt <= '0;
                    end
                end

                DRIVE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                    if (settle_cnt == SETTLE_LAST)
                        state <= SAMPLE;
                end

                SAMPLE: begin
                    err_mask <= mask_next;
                    if (vec_idx == 2'd3) begin
                        state <= DONE;
                        done  <= 1'b1;
                        // Decided from the mask including this final sample so
                        // pass is already valid alongside the done pulse.
                        pass  <= (mask_next == '0);
                    end else begin
                        vec_idx    <= vec_idx + 2'd1;
                        settle_cnt <= '0;
                        state      <= DRIVE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
module tb_gate_truth_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start3 = 1'b0;
    logic [6:0] g1, g3;
    logic       a1, b1, busy1, done1, pass1;
    logic       a3, b3, busy3, done3, pass3;
    logic [1:0] vec1, vec3;
    logic [6:0] err1, err3;
    int         f1 = 0, f3 = 0;     // fault mode: 0 none, 1 XOR stuck 0, 2 AND 0 at A=B=1
    logic       cur = 1'b1;         // 1: SETTLE_CYCLES=1 instance, 0: SETTLE_CYCLES=3 instance

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gate_truth_checker #(.SETTLE_CYCLES(1)) u_chk1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .gate_in(g1),
        .a_out(a1), .b_out(b1), .busy(busy1), .vec_idx(vec1),
        .done(done1), .pass(pass1), .err_mask(err1)
    );

    gate_truth_checker #(.SETTLE_CYCLES(3)) u_chk3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .gate_in(g3),
        .a_out(a3), .b_out(b3), .busy(busy3), .vec_idx(vec3),
        .done(done3), .pass(pass3), .err_mask(err3)
    );

    // Gate block models with fault override
    always_comb begin
        g1 = {~(a1 ^ b1), a1 ^ b1, ~(a1 | b1), ~(a1 & b1), ~a1, a1 | b1, a1 & b1};
        if (f1 == 1) g1[5] = 1'b0;
        if (f1 == 2 && a1 && b1) g1[0] = 1'b0;
    end

    always_comb begin
        g3 = {~(a3 ^ b3), a3 ^ b3, ~(a3 | b3), ~(a3 & b3), ~a3, a3 | b3, a3 & b3};
        if (f3 == 1) g3[5] = 1'b0;
        if (f3 == 2 && a3 && b3) g3[0] = 1'b0;
    end

    logic       m_a, m_b, m_busy, m_done, m_pass;
    logic [1:0] m_vec;
    logic [6:0] m_err;
    assign m_a    = cur ? a1    : a3;
    assign m_b    = cur ? b1    : b3;
    assign m_busy = cur ? busy1 : busy3;
    assign m_done = cur ? done1 : done3;
    assign m_pass = cur ? pass1 : pass3;
    assign m_vec  = cur ? vec1  : vec3;
    assign m_err  = cur ? err1  : err3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_start(input logic v);
        if (cur) start1 = v;
        else     start3 = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_a"},    m_a,    0);
        check({tag, "_b"},    m_b,    0);
        check({tag, "_vec"},  m_vec,  0);
        check({tag, "_busy"}, m_busy, 0);
        check({tag, "_done"}, m_done, 0);
        check({tag, "_pass"}, m_pass, 0);
        check({tag, "_err"},  m_err,  0);
    endtask

    // One sweep starting in the current cycle (cycle 0). Returns in the
    // IDLE cycle right after done, so another sweep can follow back-to-back.
    task automatic sweep(input int s, input logic [6:0] exp_mask, input logic [6:0] exp_pre,
                         input logic exp_pass, input int ra, input int rb);
        int dc;
        int first_done;
        int ndone;
        dc = 1 + 4 * (s + 1);
        first_done = -1;
        ndone = 0;
        set_start(1'b1);
        step();
        set_start(1'b0);
        check("busy_c1", m_busy, 1);
        check("mask_clr_c1", m_err, 0);
        check("pass_clr_c1", m_pass, 0);
        for (int c = 1; c <= dc + 1; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (c == 1 + k * (s + 1)) begin
                    check("ab_vec", {m_a, m_b}, k);
                    check("vec_idx", m_vec, k);
                end
            end
            if (c == dc - 1) check("mask_pre_last", m_err, exp_pre);
            if (m_done) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
            if (c == dc) begin
                check("done_pulse", m_done, 1);
                check("pass_at_done", m_pass, exp_pass);
                check("mask_at_done", m_err, exp_mask);
            end
            if (c == dc + 1) begin
                check("busy_after", m_busy, 0);
                check("pass_hold", m_pass, exp_pass);
                check("mask_hold", m_err, exp_mask);
            end
            if (c < dc + 1) begin
                set_start((c == ra) || (c == rb));
                step();
            end
        end
        set_start(1'b0);
        check("done_cycle", first_done, dc);
        check("done_count", ndone, 1);
    endtask

    initial begin
        // Reset state
        #2;
        cur = 1'b1; check_idle_zero("rst1");
        cur = 1'b0; check_idle_zero("rst3");
        step();
        rst_n = 1'b1;
        step();

        // Healthy, SETTLE_CYCLES=1
        cur = 1'b1; f1 = 0;
        sweep(1, 7'h00, 7'h00, 1'b1, -1, -1);
        step();

        // XOR stuck at 0
        f1 = 1;
        sweep(1, 7'b0100000, 7'b0100000, 1'b0, -1, -1);
        step();

        // AND 0 only at A=B=1: mask clear until the vector-11 sample lands
        f1 = 2;
        sweep(1, 7'b0000001, 7'b0000000, 1'b0, -1, -1);
        step();

        // Healthy, SETTLE_CYCLES=3
        cur = 1'b0; f3 = 0;
        sweep(3, 7'h00, 7'h00, 1'b1, -1, -1);
        step();

        // Starts while busy ignored; back-to-back sweep clears the mask
        cur = 1'b1; f1 = 1;
        sweep(1, 7'b0100000, 7'b0100000, 1'b0, 3, 9);
        f1 = 0;
        sweep(1, 7'h00, 7'h00, 1'b1, -1, -1);
        step();

        // Async reset during vector 10 with a fault present
        f1 = 1;
        set_start(1'b1);
        step();
        set_start(1'b0);
        step(); step(); step(); step();     // cycle 5: vector 10
        check("rst_pre_ab", {m_a, m_b}, 2'b10);
        check("rst_pre_err", m_err, 7'b0100000);
        #2 rst_n = 1'b0;
        #1;
        check_idle_zero("rst_async");
        step();
        rst_n = 1'b1;
        step(); step(); step();
        check_idle_zero("rst_release");
        f1 = 0;
        sweep(1, 7'h00, 7'h00, 1'b1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Self-test sequencer that sits around the seven-output two-input gate block. It drives that block's A/B inputs through all four input combinations, then samples the block's seven outputs after a programmable settle time and compares them against the expected truth table. The result is a per-gate error mask plus a pass flag. It is used as the built-in checker for the gate block in both bring-up and regression.

## Interface
Parameters:
- SETTLE_CYCLES, default 1, number of cycles A/B are held before sampling; legal range 1..15.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a sweep; honoured only in IDLE.
- gate_in  input  7  gate block outputs: bit0 AND, bit1 OR, bit2 NOT(A), bit3 NAND, bit4 NOR, bit5 XOR, bit6 XNOR.
- a_out  output  1  drives gate block A.
- b_out  output  1  drives gate block B.
- busy  output  1  high in any state except IDLE.
- vec_idx  output  2  current vector, with a_out = vec_idx[1] and b_out = vec_idx[0].
- done  output  1  single-cycle pulse at end of sweep.
- pass  output  1  high when the last completed sweep had err_mask == 0.
- err_mask  output  7  sticky per-gate mismatch bits for the last or current sweep.

## Operation
- FSM states and transitions:
  - IDLE: if start=1, go to DRIVE. Set vec_idx=0, clear err_mask, clear pass, load settle counter=0.
  - DRIVE: a_out/b_out are registered from vec_idx. Counter increments. After SETTLE_CYCLES cycles in DRIVE, go to SAMPLE.
  - SAMPLE: one cycle. Compute err_mask |= gate_in ^ expected(vec_idx). If vec_idx==3, go to DONE. Otherwise increment vec_idx, reset the counter and go to DRIVE.
  - DONE: one cycle. done=1; pass = (err_mask == 0), using the final mask including the last SAMPLE update. Go to IDLE.
- Expected vector for (a,b):
  - AND = a&b, OR = a|b, NOT = ~a, NAND = ~(a&b)
  - NOR = ~(a|b), XOR = a^b, XNOR = ~(a^b)
- Vector order: 00, 01, 10, 11 (A,B).
- pass and err_mask hold their values after DONE until the next accepted start.
- start while busy (DRIVE, SAMPLE or DONE) is ignored. It is neither queued nor allowed to restart the sweep.
- gate_in is treated as purely combinational from a_out/b_out. With SETTLE_CYCLES ≥ 1, the sampled value reflects the current vector.

## Timing
- Reset values: a_out=0, b_out=0, vec_idx=0, busy=0, done=0, pass=0, err_mask=0, state=IDLE.
- Reset asserted mid-sweep: all outputs go to their reset values immediately (asynchronously). No partial result is retained. A sweep restarts only on a new start after release.
- Cycle 0: start is sampled high in IDLE.
- Cycle 1: busy=1, a_out/b_out=00.
- Each vector occupies SETTLE_CYCLES + 1 cycles.
- done is high in cycle 1 + 4·(SETTLE_CYCLES+1), e.g. cycle 9 for SETTLE_CYCLES=1 and cycle 17 for SETTLE_CYCLES=3.
- busy falls in the cycle after done.
- pass and err_mask are valid in the done cycle.
- A start in the IDLE cycle immediately after DONE is accepted, giving back-to-back sweeps with a one-cycle IDLE gap.
- Settle counter width is 4 bits; it never wraps within legal parameter values.

## Structure
- Shared package gate_check_pkg:
  - state enum {IDLE, DRIVE, SAMPLE, DONE}.
  - localparams for gate bit indices (GATE_AND=0 … GATE_XNOR=6).
  - function expected_gates(a, b) returning logic [6:0].
- Single module with no sub-modules: the FSM, settle counter, vector counter and error accumulator are small enough to stay flat.
- The testbench instantiates the gate block between a_out/b_out and gate_in, plus a fault-injection override on gate_in.

## Test plan
- Healthy gate block, SETTLE_CYCLES=1, start pulse at cycle 0 → a_out/b_out sequence 00,01,10,11; done at cycle 9; pass=1; err_mask=7'h00.
- XOR output forced to 0 → err_mask=7'b0100000 (set at vector 01), pass=0, done still at cycle 9.
- AND output forced to 0 only when A=B=1 → err_mask=7'b0000001, first set in the vector-11 SAMPLE cycle.
- SETTLE_CYCLES=3, healthy block → each vector held 3 cycles, done at cycle 17, pass=1.
- start pulsed again in cycles 3 and 9 of a running sweep → ignored, single done pulse. A start at cycle 10 (IDLE) begins a new sweep with err_mask cleared.
- rst_n pulled low during vector 10 with a fault injected → all outputs are zero immediately. After release with no start, outputs stay at reset values. A fresh start with the fault removed gives pass=1.
